// File: rtl/audio_pkg.sv
// Shared constants and arithmetic helpers for the audio output path.
package audio_pkg;

    localparam int UNITY_GAIN = 8;
    localparam int VOL_SHIFT  = $clog2(UNITY_GAIN);

    // Clamp a sign-extended value into the signed range of out_bits.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                    input int                 out_bits);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_bits - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_bits - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Two's complement to offset binary: silence maps to unsigned midscale.
    function automatic logic [31:0] offset_binary(input logic [31:0] x, input int bits);
        return x ^ (32'd1 << (bits - 1));
    endfunction

endpackage

// File: rtl/audio_pwm_dac.sv
// Single-bit PWM DAC: free-running carrier, duty latched only at period end.
module audio_pwm_dac #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty_next,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_active_q;
    logic                pwm_out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_q     <= '0;
            duty_active_q <= DUTY_MID;
            pwm_out_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_out_q <= (pwm_cnt_q < duty_active_q);
            if (pwm_cnt_q == CNT_MAX) begin
                duty_active_q <= duty_next;
            end
        end
    end

    assign pwm_out = pwm_out_q;

endmodule

// File: rtl/audio_mixer_pwm.sv
// Sample-rate strobe, channel mixer with master volume and saturation, PWM DAC output.
module audio_mixer_pwm
    import audio_pkg::*;
#(
    parameter int AUD_BITS   = 12,
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_DIV = 2083,
    parameter int PWM_BITS   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*AUD_BITS-1:0] ch_audio,
    input  logic [3:0]                 volume,
    output logic                       aud_valid,
    output logic [AUD_BITS-1:0]        mix_out,
    output logic                       mix_valid,
    output logic                       clip,
    output logic                       pwm_out
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SUM_W  = AUD_BITS + $clog2(NUM_CH);
    localparam int PROD_W = SUM_W + 5;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
    logic                       aud_valid_q;
    logic                       cap_tok_q, s1_tok_q, s3_tok_q;
    logic [NUM_CH*AUD_BITS-1:0] ch_q;
    logic signed [SUM_W-1:0]    sum_d;
    logic signed [PROD_W-1:0]   prod_q, prod_d;
    logic signed [PROD_W-1:0]   shifted;
    logic signed [31:0]         sat_val;
    logic [AUD_BITS-1:0]        mix_out_q;
    logic                       mix_valid_q, clip_q;
    logic [PWM_BITS-1:0]        duty_next;

    always_comb begin
        // NOTE: every always_comb output is assigned before any branch, so no latch can form.
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        sum_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_d = sum_d + SUM_W'($signed(ch_q[i*AUD_BITS +: AUD_BITS]));
        end
        prod_d    = PROD_W'(sum_d) * PROD_W'($signed({1'b0, volume}));
        shifted   = prod_q >>> VOL_SHIFT;
        sat_val   = saturate(32'(shifted), AUD_BITS);
        duty_next = PWM_BITS'(offset_binary(32'(mix_out_q), AUD_BITS) >> (AUD_BITS - PWM_BITS));
    end

    // The channel sum is folded in front of the volume register so that
    // mix_valid lands exactly four cycles after aud_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are cleared too, so a reset never leaks a stale sample.
            div_cnt_q   <= '0;
            aud_valid_q <= 1'b0;
            cap_tok_q   <= 1'b0;
            s1_tok_q    <= 1'b0;
            s3_tok_q    <= 1'b0;
            ch_q        <= '0;
            prod_q      <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            aud_valid_q <= (div_cnt_d == DIV_LAST);
            cap_tok_q   <= aud_valid_q;
            s1_tok_q    <= cap_tok_q;
            s3_tok_q    <= s1_tok_q;
            mix_valid_q <= s3_tok_q;
            clip_q      <= 1'b0;
            if (cap_tok_q) begin
                ch_q <= ch_audio;
            end
            if (s1_tok_q) begin
                prod_q <= prod_d;
            end
            if (s3_tok_q) begin
                mix_out_q <= AUD_BITS'(sat_val);
                clip_q    <= (sat_val != 32'(shifted));
            end
        end
    end

    audio_pwm_dac #(
        .PWM_BITS (PWM_BITS)
    ) u_dac (
        .clk       (clk),
        .reset     (reset),
        .duty_next (duty_next),
        .pwm_out   (pwm_out)
    );

    assign aud_valid = aud_valid_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_audio_mixer_pwm.sv
// Self-checking bench for audio_mixer_pwm: per-cycle behavioural model plus directed and random samples.
`timescale 1ns/100ps
module tb_audio_mixer_pwm;

    localparam int AB  = 12;
    localparam int NCH = 4;
    localparam int DIV = 2083;
    localparam int PB  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH*AB-1:0] ch_audio = '0;
    logic [3:0]        volume = 4'd8;
    logic              aud_valid, mix_valid, clip, pwm_out;
    logic [AB-1:0]     mix_out;

    int n_cmp = 0;
    int n_bad = 0;

    audio_mixer_pwm #(
        .AUD_BITS   (AB),
        .NUM_CH     (NCH),
        .SAMPLE_DIV (DIV),
        .PWM_BITS   (PB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_audio  (ch_audio),
        .volume    (volume),
        .aud_valid (aud_valid),
        .mix_out   (mix_out),
        .mix_valid (mix_valid),
        .clip      (clip),
        .pwm_out   (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Mixer rule: gain = volume/8, floor, clamp to the 12-bit signed range.
    function automatic void model_mix(input int sum, input int vol, output int m, output bit clp);
        int q;
        q   = int'($floor(real'(sum * vol) / 8.0));
        clp = 1'b0;
        m   = q;
        if (q > 2047)  begin m = 2047;  clp = 1'b1; end
        if (q < -2048) begin m = -2048; clp = 1'b1; end
    endfunction

    function automatic int ch_sum();
        int s = 0;
        for (int i = 0; i < NCH; i++) s += int'($signed(ch_audio[i*AB +: AB]));
        return s;
    endfunction

    // ---------------- per-cycle compare process ----------------
    realtime last_pos = 0, last_fall = 0, last_neg = 0;
    always @(posedge clk)   last_pos  = $realtime;
    always @(negedge reset) last_fall = $realtime;

    int idx = -1;
    int av_t = 0;
    bit pend = 0;
    int snap_sum = 0;
    int nxt_mix = 0;
    bit nxt_clip = 0;
    int exp_mix = 0;

    always @(negedge clk) begin
        bit exp_av, exp_mv;
        if (reset) begin
            idx = -1; pend = 0; exp_mix = 0;
            check(aud_valid == 0 && mix_valid == 0 && clip == 0 && mix_out == 0 && pwm_out == 0,
                  "outputs_in_reset", int'({aud_valid, mix_valid, clip, pwm_out}), 0);
        end else begin
            if (last_fall > last_neg) begin
                idx = (last_pos > last_fall) ? 1 : 0;
                pend = 0; exp_mix = 0;
            end else begin
                idx++;
            end
            exp_av = (idx % DIV) == DIV - 1;
            exp_mv = pend && (idx == av_t + 4);
            if (pend && idx == av_t + 1) snap_sum = ch_sum();
            if (pend && idx == av_t + 2) model_mix(snap_sum, int'(volume), nxt_mix, nxt_clip);
            if (exp_mv) begin
                exp_mix = nxt_mix;
                pend = 0;
            end
            check(aud_valid == exp_av, "aud_valid", int'(aud_valid), int'(exp_av));
            check(mix_valid == exp_mv, "mix_valid", int'(mix_valid), int'(exp_mv));
            check(clip == (exp_mv && nxt_clip), "clip", int'(clip), int'(exp_mv && nxt_clip));
            check(int'($signed(mix_out)) == exp_mix, "mix_out", int'($signed(mix_out)), exp_mix);
            if (exp_av) begin
                pend = 1;
                av_t = idx;
            end
        end
        last_neg = $realtime;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input int c0, input int c1, input int c2, input int c3, input int v);
        ch_audio = {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
        volume   = 4'(v);
    endtask

    task automatic wait_mix(input string name);
        bit seen = 0;
        for (int k = 0; k < 2 * DIV && !seen; k++) begin
            @(negedge clk);
            seen = mix_valid;
        end
        check(seen, {name, "_timeout"}, int'(seen), 1);
        #1;
    endtask

    task automatic run_sample(input int c0, input int c1, input int c2, input int c3, input int v,
                              input int exp_m, input bit exp_c, input string name);
        set_in(c0, c1, c2, c3, v);
        wait_mix(name);
        check(int'($signed(mix_out)) == exp_m, {name, "_mix"}, int'($signed(mix_out)), exp_m);
        check(clip == exp_c, {name, "_clip"}, int'(clip), int'(exp_c));
    endtask

    task automatic pwm_high(input int exp_hi, input string name);
        int hi = 0;
        repeat (600) @(negedge clk);
        repeat (1 << PB) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        check(hi == exp_hi, name, hi, exp_hi);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int av_at[3];
        int n_av, first_av, m;
        bit seen_mv, clp;
        int c[4];
        int v;

        set_in(1000, 1000, 0, 0, 8);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        // Divider: count cycles from release (first negedge lies in cycle 1).
        n_av = 0;
        for (int n = 1; n <= 7000 && n_av < 3; n++) begin
            @(negedge clk);
            if (aud_valid) begin
                av_at[n_av] = n;
                n_av++;
            end
        end
        check(n_av == 3, "divider_count", n_av, 3);
        check(av_at[0] == 2082, "aud_valid_1", av_at[0], 2082);
        check(av_at[1] == 4165, "aud_valid_2", av_at[1], 4165);
        check(av_at[2] == 6248, "aud_valid_3", av_at[2], 6248);
        wait_mix("unity");
        check(int'($signed(mix_out)) == 2000, "unity_mix", int'($signed(mix_out)), 2000);
        check(clip == 1'b0, "unity_clip", int'(clip), 0);

        run_sample(2047, 2047, 2047, 2047, 8, 2047, 1'b1, "sat_pos");
        run_sample(-2048, -2048, -2048, -2048, 8, -2048, 1'b1, "sat_neg");
        run_sample(1000, 0, 0, 0, 4, 500, 1'b0, "vol_half");
        run_sample(-3, 0, 0, 0, 4, -2, 1'b0, "vol_floor");
        run_sample(1000, 0, 0, 0, 0, 0, 1'b0, "vol_mute");
        run_sample(1200, 0, 0, 0, 15, 2047, 1'b1, "vol_max");

        run_sample(0, 0, 0, 0, 8, 0, 1'b0, "pwm_mid_mix");
        pwm_high(128, "pwm_mid");
        run_sample(2047, 0, 0, 0, 8, 2047, 1'b0, "pwm_max_mix");
        pwm_high(255, "pwm_max");
        run_sample(-2048, 0, 0, 0, 8, -2048, 1'b0, "pwm_min_mix");
        pwm_high(0, "pwm_min");

        // Async reset while a sample sits in the pipeline.
        set_in(500, 0, 0, 0, 8);
        seen_mv = 0;
        for (int k = 0; k < 2 * DIV && !seen_mv; k++) begin
            @(negedge clk);
            seen_mv = aud_valid;
        end
        check(seen_mv, "rst_wait_av", int'(seen_mv), 1);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #0.5;
        check(aud_valid == 0 && mix_valid == 0 && clip == 0, "rst_flags",
              int'({aud_valid, mix_valid, clip}), 0);
        check(mix_out == '0, "rst_mix_out", int'($signed(mix_out)), 0);
        check(pwm_out == 1'b0, "rst_pwm_out", int'(pwm_out), 0);
        #0.5 reset = 1'b0;
        first_av = -1;
        seen_mv  = 0;
        for (int k = 0; k < DIV + 100 && first_av < 0; k++) begin
            @(negedge clk);
            if (mix_valid) seen_mv = 1;
            if (aud_valid) first_av = k;
        end
        check(first_av == DIV - 1, "rst_first_av", first_av, DIV - 1);
        check(!seen_mv, "rst_no_mix_valid", int'(seen_mv), 0);
        #1;
        run_sample(500, 0, 0, 0, 8, 500, 1'b0, "post_rst");

        // Random samples, each followed by a PWM duty measurement.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 4095)) - 2048;
            v = int'($urandom_range(0, 15));
            model_mix(c[0] + c[1] + c[2] + c[3], v, m, clp);
            run_sample(c[0], c[1], c[2], c[3], v, m, clp, "rand");
            pwm_high((m + 2048) / 16, "rand_pwm");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
